// File: rtl/dual_chan_fifo_reader_pkg.sv
// Shared types and defaults for the dual-channel FIFO read-side drain engine.
package dual_chan_fifo_reader_pkg;

    // Arbitration FSM states: idle, or draining a burst from one channel.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CH0  = 2'd1,
        ST_CH1  = 2'd2
    } rd_state_e;

    localparam int DEF_FIFO_WIDTH = 32;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_BUF_DEPTH  = 4;
    localparam int CHAN_TAG_W     = 1;

    // Maps a channel number onto the FSM state that drains it.
    function automatic rd_state_e chanState(input logic chan);
        return chan ? ST_CH1 : ST_CH0;
    endfunction

endpackage

// File: rtl/dual_chan_fifo_reader_if.sv
// Bundle of the two FIFO read ports plus the tagged output stream.
// master = the drain engine, slave = FIFOs and downstream consumer.
interface dual_chan_fifo_reader_if
    import dual_chan_fifo_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
);
    logic                  read_en_chan0;
    logic [FIFO_WIDTH-1:0] read_data_chan0;
    logic                  fifo_empty_chan0;
    logic                  read_en_chan1;
    logic [FIFO_WIDTH-1:0] read_data_chan1;
    logic                  fifo_empty_chan1;
    logic                  out_valid;
    logic                  out_ready;
    logic [FIFO_WIDTH-1:0] out_data;
    logic                  out_chan;

    modport master (
        output read_en_chan0, read_en_chan1, out_valid, out_data, out_chan,
        input  read_data_chan0, fifo_empty_chan0, read_data_chan1, fifo_empty_chan1, out_ready
    );

    modport slave (
        input  read_en_chan0, read_en_chan1, out_valid, out_data, out_chan,
        output read_data_chan0, fifo_empty_chan0, read_data_chan1, fifo_empty_chan1, out_ready
    );
endinterface

// File: rtl/dual_chan_fifo_reader_skid.sv
// Small synchronous FIFO that buffers tagged words ahead of the output stream.
// The head entry is read straight out of storage registers, so the output has
// no combinational path from the push side. DEPTH must be a power of two so
// the pointers wrap naturally.
module rd_skid_fifo
    import dual_chan_fifo_reader_pkg::*;
#(
    parameter int WIDTH = DEF_FIFO_WIDTH + CHAN_TAG_W,
    parameter int DEPTH = DEF_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push   = i_push && (r_count != FULL_CNT);
    assign w_do_pop    = i_pop && (r_count != '0);
    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    // Storage, pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/dual_chan_fifo_reader.sv
// Read-side drain engine: pops two FIFO channels with burst round-robin
// arbitration and presents one valid/ready stream tagged with the source.
// A word popped in cycle N is held in the in-flight register while the FIFO
// returns its data, then pushed into the output buffer at the end of N+1.
module dual_chan_fifo_reader
    import dual_chan_fifo_reader_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
    input logic                      rdclk,
    input logic                      rstb_rdclk,
    dual_chan_fifo_reader_if.master  bus
);
    localparam int CNT_W  = $clog2(BUF_DEPTH+1);
    localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN-1);
    localparam logic [CNT_W:0]    DEPTH_LIM  = (CNT_W+1)'(BUF_DEPTH);

    rd_state_e               r_state;
    rd_state_e               w_next_state;
    logic [BCNT_W-1:0]       r_burst_cnt;
    logic [BCNT_W-1:0]       w_next_burst_cnt;
    logic                    r_rr;
    logic                    w_next_rr;
    logic                    r_if_valid;
    logic                    r_if_chan;
    logic                    w_issue;
    logic                    w_leave;
    logic                    w_cur_chan;
    logic                    w_cur_empty;
    logic                    w_oth_empty;
    logic                    w_pref_empty;
    logic                    w_alt_empty;
    logic [CNT_W-1:0]        w_occ;
    logic [CNT_W:0]          w_credit_sum;
    logic                    w_space;
    logic [FIFO_WIDTH:0]     w_push_data;
    logic [FIFO_WIDTH:0]     w_head;
    logic                    w_pop;

    // Space check uses registered occupancy plus the in-flight word only;
    // a pop happening this cycle does not free a slot until next cycle.
    assign w_credit_sum = {1'b0, w_occ} + (CNT_W+1)'(r_if_valid);
    assign w_space      = w_credit_sum < DEPTH_LIM;

    assign w_cur_chan   = (r_state == ST_CH1);
    assign w_cur_empty  = w_cur_chan ? bus.fifo_empty_chan1 : bus.fifo_empty_chan0;
    assign w_oth_empty  = w_cur_chan ? bus.fifo_empty_chan0 : bus.fifo_empty_chan1;
    assign w_pref_empty = r_rr ? bus.fifo_empty_chan1 : bus.fifo_empty_chan0;
    assign w_alt_empty  = r_rr ? bus.fifo_empty_chan0 : bus.fifo_empty_chan1;

    assign bus.read_en_chan0 = w_issue && !w_cur_chan;
    assign bus.read_en_chan1 = w_issue && w_cur_chan;

    assign w_push_data = {r_if_chan, (r_if_chan ? bus.read_data_chan1 : bus.read_data_chan0)};
    assign w_pop       = bus.out_valid && bus.out_ready;

    assign bus.out_valid = (w_occ != '0);
    assign bus.out_data  = w_head[FIFO_WIDTH-1:0];
    assign bus.out_chan  = w_head[FIFO_WIDTH];

    // Arbitration: pick a channel from IDLE, pop while space allows, and
    // leave on the final pop of a burst or when the channel runs dry.
    always_comb begin
        w_next_state     = r_state;
        w_next_burst_cnt = r_burst_cnt;
        w_next_rr        = r_rr;
        w_issue          = 1'b0;
        w_leave          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_pref_empty) begin
                    w_next_state = chanState(r_rr);
                end else if (!w_alt_empty) begin
                    w_next_state = chanState(~r_rr);
                end
            end
            ST_CH0, ST_CH1: begin
                if (w_space) begin
                    if (w_cur_empty) begin
                        w_leave = 1'b1;
                    end else begin
                        w_issue = 1'b1;
                        if (r_burst_cnt == BURST_LAST) begin
                            w_leave = 1'b1;
                        end else begin
                            w_next_burst_cnt = r_burst_cnt + 1'b1;
                        end
                    end
                end
                if (w_leave) begin
                    w_next_burst_cnt = '0;
                    w_next_rr        = ~w_cur_chan;
                    w_next_state     = w_oth_empty ? ST_IDLE : chanState(~w_cur_chan);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state, burst counter, round-robin pointer and in-flight tag.
    always_ff @(posedge rdclk or negedge rstb_rdclk) begin
        if (!rstb_rdclk) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
            r_rr        <= 1'b0;
            r_if_valid  <= 1'b0;
            r_if_chan   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_burst_cnt <= w_next_burst_cnt;
            r_rr        <= w_next_rr;
            r_if_valid  <= w_issue;
            r_if_chan   <= w_cur_chan;
        end
    end

    rd_skid_fifo #(
        .WIDTH (FIFO_WIDTH + CHAN_TAG_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (rdclk),
        .rst_n       (rstb_rdclk),
        .i_push      (r_if_valid),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_occ)
    );
endmodule

// File: tb/tb_dual_chan_fifo_reader.sv
// Scoreboard bench for dual_chan_fifo_reader: queue-based FIFO models feed the
// read ports, a monitor checks every delivered word against expected queues.
module tb_dual_chan_fifo_reader;
    import dual_chan_fifo_reader_pkg::*;

    localparam int W  = 32;
    localparam int BL = 4;
    localparam int BD = 4;

    logic rdclk      = 1'b0;
    logic rstb_rdclk = 1'b0;

    always #5 rdclk = ~rdclk;

    dual_chan_fifo_reader_if #(.FIFO_WIDTH(W)) bus ();

    dual_chan_fifo_reader #(
        .FIFO_WIDTH (W),
        .BURST_LEN  (BL),
        .BUF_DEPTH  (BD)
    ) dut (
        .rdclk      (rdclk),
        .rstb_rdclk (rstb_rdclk),
        .bus        (bus)
    );

    int checks = 0;
    int passes = 0;

    logic [W-1:0] fifoQ0 [$];
    logic [W-1:0] fifoQ1 [$];
    logic [W-1:0] expQ0  [$];
    logic [W-1:0] expQ1  [$];
    bit           expChanQ [$];
    bit           strictOrder = 1'b1;
    bit           randomReady = 1'b0;
    int           popCount = 0;

    logic [W-1:0] pend0 = '0;
    logic [W-1:0] pend1 = '0;
    logic         newEmpty0 = 1'b1;
    logic         newEmpty1 = 1'b1;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Load n sequential words into one channel's FIFO model and the scoreboard.
    task automatic applyStimulus(input int ch, input int n, input logic [W-1:0] base);
        for (int i = 0; i < n; i++) begin
            if (ch == 0) begin
                fifoQ0.push_back(base + W'(i));
                expQ0.push_back(base + W'(i));
            end else begin
                fifoQ1.push_back(base + W'(i));
                expQ1.push_back(base + W'(i));
            end
        end
    endtask

    task automatic pushChanSeq(input bit ch, input int n);
        for (int i = 0; i < n; i++) expChanQ.push_back(ch);
    endtask

    task automatic clearModel();
        fifoQ0.delete(); fifoQ1.delete();
        expQ0.delete();  expQ1.delete();
        expChanQ.delete();
    endtask

    // Async reset: outputs must drop immediately, then release on a clean cycle.
    task automatic doReset();
        rstb_rdclk = 1'b0;
        clearModel();
        #1;
        checkOutput("rst_out_valid", W'(bus.out_valid), '0);
        checkOutput("rst_out_data",  bus.out_data,      '0);
        checkOutput("rst_out_chan",  W'(bus.out_chan),  '0);
        checkOutput("rst_read_en0",  W'(bus.read_en_chan0), '0);
        checkOutput("rst_read_en1",  W'(bus.read_en_chan1), '0);
        repeat (3) @(posedge rdclk);
        #1 rstb_rdclk = 1'b1;
        @(posedge rdclk);
        #1;
    endtask

    task automatic waitDrain(input string name, input int maxCycles);
        int n;
        n = 0;
        while ((expQ0.size() != 0 || expQ1.size() != 0) && n < maxCycles) begin
            @(posedge rdclk);
            #1;
            n++;
        end
        checks++;
        if (expQ0.size() == 0 && expQ1.size() == 0 && expChanQ.size() == 0) passes++;
        else $display("[TB] FAIL %s_drain: remaining ch0=%0d ch1=%0d seq=%0d required 0",
                      name, expQ0.size(), expQ1.size(), expChanQ.size());
    endtask

    // FIFO model: sample pops mid-cycle, check the pop rules, queue the data.
    always @(negedge rdclk) begin
        if (rstb_rdclk) begin
            if (bus.read_en_chan0 || bus.read_en_chan1) begin
                checks++;
                if ((bus.read_en_chan0 && bus.read_en_chan1) ||
                    (bus.read_en_chan0 && (bus.fifo_empty_chan0 || fifoQ0.size() == 0)) ||
                    (bus.read_en_chan1 && (bus.fifo_empty_chan1 || fifoQ1.size() == 0)))
                    $display("[TB] FAIL pop_rule: en0=%0b en1=%0b empty0=%0b empty1=%0b required legal pop",
                             bus.read_en_chan0, bus.read_en_chan1, bus.fifo_empty_chan0, bus.fifo_empty_chan1);
                else passes++;
            end
            if (bus.read_en_chan0 && fifoQ0.size() > 0) begin
                pend0 = fifoQ0.pop_front();
                popCount++;
            end
            if (bus.read_en_chan1 && fifoQ1.size() > 0) begin
                pend1 = fifoQ1.pop_front();
                popCount++;
            end
        end
        newEmpty0 = (fifoQ0.size() == 0);
        newEmpty1 = (fifoQ1.size() == 0);
    end

    // FIFO model outputs change on the clock edge like a real registered FIFO.
    always @(posedge rdclk or negedge rstb_rdclk) begin
        if (!rstb_rdclk) begin
            bus.fifo_empty_chan0 <= 1'b1;
            bus.fifo_empty_chan1 <= 1'b1;
            bus.read_data_chan0  <= '0;
            bus.read_data_chan1  <= '0;
        end else begin
            bus.fifo_empty_chan0 <= newEmpty0;
            bus.fifo_empty_chan1 <= newEmpty1;
            bus.read_data_chan0  <= pend0;
            bus.read_data_chan1  <= pend1;
        end
    end

    always @(posedge rdclk) begin
        if (randomReady) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: checks every accepted word and stability while stalled.
    bit           prevStall = 1'b0;
    logic [W-1:0] prevData  = '0;
    logic         prevChan  = 1'b0;
    always @(negedge rdclk) begin
        if (!rstb_rdclk) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checks++;
                if (bus.out_valid && bus.out_data == prevData && bus.out_chan == prevChan) passes++;
                else $display("[TB] FAIL stall_stable: got v=%0b %0b/%h required v=1 %0b/%h",
                              bus.out_valid, bus.out_chan, bus.out_data, prevChan, prevData);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (strictOrder) begin
                    checks++;
                    if (expChanQ.size() == 0)
                        $display("[TB] FAIL chan_order: got %0d required none", bus.out_chan);
                    else begin
                        bit ec;
                        ec = expChanQ.pop_front();
                        if (bus.out_chan == ec) passes++;
                        else $display("[TB] FAIL chan_order: got %0d required %0d", bus.out_chan, ec);
                    end
                end
                checks++;
                if (bus.out_chan == 1'b0 && expQ0.size() == 0)
                    $display("[TB] FAIL data_ch0: got %h required none", bus.out_data);
                else if (bus.out_chan == 1'b1 && expQ1.size() == 0)
                    $display("[TB] FAIL data_ch1: got %h required none", bus.out_data);
                else begin
                    logic [W-1:0] ed;
                    ed = bus.out_chan ? expQ1.pop_front() : expQ0.pop_front();
                    if (bus.out_data == ed) passes++;
                    else $display("[TB] FAIL data_ch%0d: got %h required %h", bus.out_chan, bus.out_data, ed);
                end
            end
            prevStall = bus.out_valid && !bus.out_ready;
            prevData  = bus.out_data;
            prevChan  = bus.out_chan;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        doReset();

        // Single channel stream.
        applyStimulus(0, 10, 32'h0000_1000);
        pushChanSeq(1'b0, 10);
        waitDrain("t1", 200);

        // Both channels, burst round-robin.
        doReset();
        applyStimulus(0, 8, 32'h0000_A000);
        applyStimulus(1, 8, 32'h0000_B000);
        for (int b = 0; b < 4; b++) pushChanSeq(1'(b % 2), 4);
        waitDrain("t2", 200);

        // Channel 0 runs dry mid-burst.
        doReset();
        applyStimulus(0, 2, 32'h0000_C000);
        applyStimulus(1, 4, 32'h0000_D000);
        pushChanSeq(1'b0, 2);
        pushChanSeq(1'b1, 4);
        waitDrain("t3", 200);

        // Consumer stalled with plenty queued.
        doReset();
        bus.out_ready = 1'b0;
        popCount = 0;
        applyStimulus(0, 8, 32'h0000_E000);
        applyStimulus(1, 8, 32'h0000_F000);
        for (int b = 0; b < 4; b++) pushChanSeq(1'(b % 2), 4);
        repeat (20) @(posedge rdclk);
        #1;
        checkOutput("stall_pops", W'(popCount), W'(BD));
        checkOutput("stall_valid", W'(bus.out_valid), W'(1));
        bus.out_ready = 1'b1;
        waitDrain("t4", 300);

        // Random backpressure, long traffic, per-channel ordering only.
        doReset();
        strictOrder = 1'b0;
        randomReady = 1'b1;
        applyStimulus(0, 1000, 32'h5000_0000);
        applyStimulus(1, 1000, 32'h6000_0000);
        waitDrain("t5", 20000);
        randomReady = 1'b0;
        @(posedge rdclk);
        #2;
        bus.out_ready = 1'b1;
        strictOrder = 1'b1;

        // Reset with three words buffered and one in flight.
        doReset();
        bus.out_ready = 1'b0;
        popCount = 0;
        applyStimulus(0, 4, 32'h0000_7000);
        pushChanSeq(1'b0, 4);
        for (int n = 0; n < 50 && popCount < 4; n++) begin
            @(posedge rdclk);
            #1;
        end
        checkOutput("t6_pops", W'(popCount), W'(4));
        checkOutput("t6_valid_pre", W'(bus.out_valid), W'(1));
        checkOutput("t6_data_pre", bus.out_data, 32'h0000_7000);
        doReset();
        bus.out_ready = 1'b1;
        applyStimulus(1, 1, 32'h0000_8001);
        applyStimulus(0, 1, 32'h0000_8000);
        pushChanSeq(1'b0, 1);
        pushChanSeq(1'b1, 1);
        waitDrain("t6", 100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
